// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file writeback arbiter:
// register address width, register count, default data width, the register
// address type and a writeback request record {addr, data}.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int XLEN       = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t       addr;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundle of the NUM_REQ writeback requester handshakes.
//   req_valid [NUM_REQ]        requester i has a pending write
//   req_ready [NUM_REQ]        requester i is granted this cycle
//   req_addr  [NUM_REQ*5]      destination register, requester i at [5i+4:5i]
//   req_data  [NUM_REQ*XLEN]   write data, requester i at [XLEN*i +: XLEN]
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
   logic [NUM_REQ*XLEN-1:0]       req_data;

   modport master (output req_valid, output req_addr, output req_data, input req_ready);
   modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_rr_arbiter
// One-hot grant generator for NUM_REQ requesters.
//   clk, rst_n   clock / asynchronous active-low reset
//   req          request vector
//   grant        one-hot grant (all zero when nothing requests)
// Default: round-robin, scan starts at an internal pointer which moves to
// one past the granted index. With WB_FIXED_PRIO_EN defined the pointer is
// removed and the lowest requesting index always wins.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter_rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant
);

`ifdef WB_FIXED_PRIO_EN

   // No state in this build; clock and reset are intentionally unused.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
         end
      end
   end

`else

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;

   // Two passes implement the wrap-around scan: first indices at or above
   // the pointer, then from zero if nothing was found.
   always_comb begin
      logic found;
      grant    = '0;
      ptr_next = ptr_reg;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i >= int'(ptr_reg))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            ptr_next = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            ptr_next = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register-file write port between NUM_REQ writeback requesters
// and keeps a scoreboard of outstanding destination registers.
//   clk, rst_n    clock / asynchronous active-low reset
//   req           requester handshakes (regfile_wb_arbiter_if.slave)
//   wen/waddr/wdata  registered register-file write port
//   issue_valid/issue_rd  issued instruction with destination register
//   busy[32]      bit r set while a write to xr is outstanding
// Optional build macro: WB_FIXED_PRIO_EN (fixed lowest-index priority instead
// of round-robin).
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_wb_arbiter_if.slave   req,
   output logic                  wen,
   output reg_addr_t             waddr,
   output logic [XLEN-1:0]       wdata,
   input  logic                  issue_valid,
   input  reg_addr_t             issue_rd,
   output logic [NUM_REGS-1:0]   busy
);

   logic [NUM_REQ-1:0]  arb_req;
   logic [NUM_REQ-1:0]  grant;
   reg_addr_t           sel_addr;
   logic [XLEN-1:0]     sel_data;
   logic                wen_reg;
   reg_addr_t           waddr_reg;
   logic [XLEN-1:0]     wdata_reg;
   logic [NUM_REGS-1:0] busy_vec;

   // Nobody is granted while reset is held, so requesters are never told
   // they were accepted by a write that the reset will discard.
   assign arb_req = req.req_valid & {NUM_REQ{rst_n}};

   regfile_wb_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (arb_req),
      .grant (grant)
   );

   assign req.req_ready = grant;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req.req_addr[REG_ADDR_W*i +: REG_ADDR_W];
            sel_data = req.req_data[XLEN*i +: XLEN];
         end
      end
   end

   // Writes to x0 are consumed but never reach the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_reg   <= 1'b0;
         waddr_reg <= '0;
         wdata_reg <= '0;
      end else if ((|grant) && (sel_addr != '0)) begin
         wen_reg   <= 1'b1;
         waddr_reg <= sel_addr;
         wdata_reg <= sel_data;
      end else begin
         wen_reg   <= 1'b0;
         waddr_reg <= '0;
         wdata_reg <= '0;
      end
   end

   assign wen   = wen_reg;
   assign waddr = waddr_reg;
   assign wdata = wdata_reg;

   // Scoreboard: x0 never busy. A new issue to a register beats a completing
   // write to the same register, since the issue is the newer producer.
   assign busy_vec[0] = 1'b0;

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      logic bit_reg;
      logic set_hit;
      logic clr_hit;

      assign set_hit = issue_valid && (issue_rd == reg_addr_t'(gi));
      assign clr_hit = wen_reg && (waddr_reg == reg_addr_t'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            bit_reg <= 1'b0;
         end else if (set_hit) begin
            bit_reg <= 1'b1;
         end else if (clr_hit) begin
            bit_reg <= 1'b0;
         end
      end

      assign busy_vec[gi] = bit_reg;
   end

   assign busy = busy_vec;

endmodule
